// File: rtl/z80_boot_loader.sv
// Boot sequencer: holds the Z80 core in reset, streams PROG_BYTES program bytes
// from a handshaked byte source onto the core data bus, then releases the bus.
module z80_boot_loader #(
    parameter int PROG_BYTES  = 4096,
    parameter int ADDR_W      = 12,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic              I_RELOAD,
    output logic              O_ROM_REQ,
    output logic [ADDR_W-1:0] O_ROM_ADDR,
    input  logic              I_ROM_ACK,
    input  logic [7:0]        I_ROM_DATA,
    output logic              O_CORE_N_RESET,
    output logic [7:0]        O_DATA,
    output logic              O_DATA_OE,
    output logic              O_LOAD_STB,
    output logic [ADDR_W:0]   O_LOAD_CNT,
    output logic              O_DONE
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    // One extra bit so PROG_BYTES = 2^ADDR_W still has a representable last address.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(PROG_BYTES - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_LOAD,
        S_DRAIN,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              stb_q, stb_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic rom_req;
    logic take;
    logic at_last;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        stb_d      = 1'b0;
        cnt_d      = cnt_q;

        rom_req = (state_q == S_LOAD) && ({1'b0, addr_q} <= LAST_ADDR);
        take    = rom_req && I_ROM_ACK;
        at_last = ({1'b0, addr_q} == LAST_ADDR);

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_LOAD;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                if (take) begin
                    data_d = I_ROM_DATA;
                    stb_d  = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    // Address parks on the last byte instead of wrapping.
                    if (at_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (I_RELOAD) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                    addr_d     = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= 8'h00;
            stb_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            stb_q      <= stb_d;
            cnt_q      <= cnt_d;
        end
    end

    assign O_ROM_REQ      = rom_req;
    assign O_ROM_ADDR     = addr_q;
    assign O_CORE_N_RESET = (state_q != S_HOLD);
    assign O_DATA         = data_q;
    assign O_DATA_OE      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign O_LOAD_STB     = stb_q;
    assign O_LOAD_CNT     = cnt_q;
    assign O_DONE         = (state_q == S_RUN);

endmodule

// File: tb/tb_z80_boot_loader.sv
// Directed bench for z80_boot_loader: an 8-byte image on a 3-bit address
// instance plus a single-byte image instance, with a strobe scoreboard.
module tb_z80_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: PROG_BYTES=8, ADDR_W=3, HOLD_CYCLES=2
    logic       rst_a = 1'b1, reload_a = 1'b0, ack_a = 1'b0;
    logic       req_a, nres_a, oe_a, stb_a, done_a;
    logic [2:0] addr_a;
    logic [7:0] rom_a, data_a;
    logic [3:0] cnt_a;
    assign rom_a = 8'hA0 + {5'd0, addr_a};

    z80_boot_loader #(.PROG_BYTES(8), .ADDR_W(3), .HOLD_CYCLES(2)) dut_a (
        .I_CLK(clk), .I_RESET(rst_a), .I_RELOAD(reload_a),
        .O_ROM_REQ(req_a), .O_ROM_ADDR(addr_a), .I_ROM_ACK(ack_a), .I_ROM_DATA(rom_a),
        .O_CORE_N_RESET(nres_a), .O_DATA(data_a), .O_DATA_OE(oe_a),
        .O_LOAD_STB(stb_a), .O_LOAD_CNT(cnt_a), .O_DONE(done_a)
    );

    // Instance B: PROG_BYTES=1, ADDR_W=4, HOLD_CYCLES=3
    logic       rst_b = 1'b1, reload_b = 1'b0, ack_b = 1'b1;
    logic       req_b, nres_b, oe_b, stb_b, done_b;
    logic [3:0] addr_b;
    logic [7:0] rom_b, data_b;
    logic [4:0] cnt_b;
    assign rom_b = 8'h5C ^ {4'd0, addr_b};

    z80_boot_loader #(.PROG_BYTES(1), .ADDR_W(4), .HOLD_CYCLES(3)) dut_b (
        .I_CLK(clk), .I_RESET(rst_b), .I_RELOAD(reload_b),
        .O_ROM_REQ(req_b), .O_ROM_ADDR(addr_b), .I_ROM_ACK(ack_b), .I_ROM_DATA(rom_b),
        .O_CORE_N_RESET(nres_b), .O_DATA(data_b), .O_DATA_OE(oe_b),
        .O_LOAD_STB(stb_b), .O_LOAD_CNT(cnt_b), .O_DONE(done_b)
    );

    int n_vec = 0, n_err = 0;
    logic [7:0] sb[$];
    int exp_addr = 0, stb_seen = 0, cyc_n = 0, first_stb = -1, last_stb = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // One clock of instance A: ack-side pushes before the edge, strobe pops after it.
    task automatic cyc(input logic ack, input logic reload, input logic rst);
        ack_a = ack; reload_a = reload; rst_a = rst;
        if (!rst && ack && req_a) begin
            if (exp_addr >= 8) chk("no_ninth_req", req_a, 0);
            else begin
                chk("req_addr", addr_a, exp_addr);
                sb.push_back(8'(8'hA0 + exp_addr));
                exp_addr++;
            end
        end
        @(posedge clk); #1;
        cyc_n++;
        if (rst) begin
            sb.delete(); exp_addr = 0; stb_seen = 0; first_stb = -1; last_stb = -1;
        end else if (stb_a) begin
            if (sb.size() == 0) chk("stb_unexpected", stb_a, 0);
            else chk("stb_data", data_a, sb.pop_front());
            stb_seen++;
            if (stb_seen == 1) first_stb = cyc_n;
            last_stb = cyc_n;
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        rst_a = 1'b0;
        cyc_n = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_nres"}, nres_a, 0);
        chk({tag, "_req"},  req_a,  0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_oe"},   oe_a,   0);
        chk({tag, "_stb"},  stb_a,  0);
        chk({tag, "_cnt"},  cnt_a,  0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 40 && !done_a; i++) cyc(1'b1, 1'b0, 1'b0);
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_strobes"}, stb_seen, 8);
        chk({tag, "_cnt"}, cnt_a, 8);
        chk({tag, "_addr"}, addr_a, 7);
        chk({tag, "_oe"}, oe_a, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    int reqs_b, stbs_b, run_b;

    initial begin
        // Ack tied high: hold, streaming, completion timing
        do_reset();
        chk_reset("rst");
        chk("nres_c0", nres_a, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("nres_c1", nres_a, 0);
        chk("req_c1", req_a, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("nres_c2", nres_a, 1);
        chk("req_c2", req_a, 1);
        chk("oe_c2", oe_a, 1);
        while (cyc_n < 10) cyc(1'b1, 1'b0, 1'b0);
        chk("done_c10", done_a, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("done_c11", done_a, 1);
        chk("first_stb_cyc", first_stb, 3);
        chk("last_stb_cyc", last_stb, 10);
        run_to_done("t1");
        cyc(1'b1, 1'b0, 1'b0);
        chk("run_ack_ignored_req", req_a, 0);
        chk("run_ack_ignored_stb", stb_a, 0);
        chk("run_cnt_hold", cnt_a, 8);

        // Ack stall at address 3
        do_reset();
        for (int i = 0; i < 20 && exp_addr < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("stall_addr", addr_a, 3);
            chk("stall_req", req_a, 1);
            chk("stall_stb", stb_a, 0);
            chk("stall_data", data_a, 8'hA2);
        end
        run_to_done("t2");

        // Reset (with reload) after 5 strobes, then full reload from address 0
        do_reset();
        for (int i = 0; i < 20 && stb_seen < 5; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk_reset("rst_mid");
        rst_a = 1'b0; cyc_n = 0;
        run_to_done("t3");
        cyc(1'b0, 1'b1, 1'b1);
        chk_reset("rst_run");
        rst_a = 1'b0; cyc_n = 0;

        // Reload ignored in LOAD, honoured in RUN
        for (int i = 0; i < 20 && stb_seen < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("reload_load_nres", nres_a, 1);
        chk("reload_load_oe", oe_a, 1);
        run_to_done("t4a");
        exp_addr = 0; stb_seen = 0;
        cyc(1'b0, 1'b1, 1'b0);
        chk("reload_run_done", done_a, 0);
        chk("reload_run_nres", nres_a, 0);
        chk("reload_run_cnt", cnt_a, 0);
        chk("reload_run_oe", oe_a, 0);
        reload_a = 1'b0;
        run_to_done("t4b");

        // Single-byte image on instance B
        @(posedge clk); #1;
        rst_b = 1'b0;
        reqs_b = 0; stbs_b = 0; run_b = -1;
        for (int c = 1; c <= 8; c++) begin
            if (req_b) begin
                reqs_b++;
                chk("b_req_addr", addr_b, 0);
            end
            @(posedge clk); #1;
            if (stb_b) begin
                stbs_b++;
                chk("b_stb_data", data_b, 8'h5C);
            end
            if (done_b && run_b < 0) run_b = c;
        end
        chk("b_reqs", reqs_b, 1);
        chk("b_stbs", stbs_b, 1);
        chk("b_run_cycle", run_b, 5);
        chk("b_cnt", cnt_b, 1);
        chk("b_addr", addr_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/z80_boot_loader.md
# z80_boot_loader

Boot sequencer for the Z80 core. It holds the core in reset, then streams a program image from an external byte source onto the core's data bus, one load strobe per byte. After the last byte it releases the bus and flags completion. It sits between the program ROM/host port and `top_z80`, and replaces open-loop bus preloading with a handshaked, counted load.

## Interface

Parameters:
- `PROG_BYTES`, default 4096: number of bytes loaded per boot; legal range 1..2^`ADDR_W`.
- `ADDR_W`, default 12: width of the ROM address.
- `HOLD_CYCLES`, default 2: cycles the core reset is held low before loading starts; must be ≥1.

Ports:
- `I_CLK`  in  1  system clock; all logic on the rising edge.
- `I_RESET`  in  1  synchronous, active-high reset.
- `I_RELOAD`  in  1  request a new boot; sampled only in RUN.
- `O_ROM_REQ`  out  1  read request to the byte source.
- `O_ROM_ADDR`  out  `ADDR_W`  byte address, valid while `O_ROM_REQ`=1.
- `I_ROM_ACK`  in  1  source accepts the request; `I_ROM_DATA` is valid in the same cycle.
- `I_ROM_DATA`  in  8  program byte.
- `O_CORE_N_RESET`  out  1  active-low reset to the core.
- `O_DATA`  out  8  byte driven toward `IO_DATA`.
- `O_DATA_OE`  out  1  bus drive enable; when 0 the top level floats the bus (8'hzz).
- `O_LOAD_STB`  out  1  one-cycle strobe: `O_DATA` holds a new program byte.
- `O_LOAD_CNT`  out  `ADDR_W`+1  bytes presented so far.
- `O_DONE`  out  1  load complete, core running.

## Operation

- States are HOLD, LOAD, DRAIN and RUN.
- HOLD:
  - `O_CORE_N_RESET`=0, `O_ROM_REQ`=0, `O_DATA_OE`=0.
  - A hold counter counts `HOLD_CYCLES` cycles, then the block enters LOAD.
  - On entry the address and `O_LOAD_CNT` are cleared.
- LOAD:
  - `O_CORE_N_RESET`=1 and `O_DATA_OE`=1.
  - `O_ROM_REQ`=1 while the address is below `PROG_BYTES`.
  - On a cycle with `O_ROM_REQ`&`I_ROM_ACK`:
    - `I_ROM_DATA` is registered into `O_DATA`.
    - `O_LOAD_STB` is pulsed on the next cycle.
    - The address increments.
  - When the ack for address `PROG_BYTES`-1 is taken, `O_ROM_REQ` drops in the following cycle and the block enters DRAIN.
- DRAIN: lasts one cycle while the final `O_LOAD_STB` is presented, then the block enters RUN.
- RUN:
  - `O_DATA_OE`=0, `O_DONE`=1, `O_ROM_REQ`=0, `O_CORE_N_RESET`=1.
  - `I_RELOAD`=1 sends the block to HOLD and clears `O_DONE`.
- `O_LOAD_CNT` increments with each `O_LOAD_STB`. It ends at exactly `PROG_BYTES` and never wraps.
- `O_ROM_ADDR` never exceeds `PROG_BYTES`-1. The next-address comparison uses `ADDR_W`+1 bits, so `PROG_BYTES`=2^`ADDR_W` terminates correctly.
- `I_ROM_ACK` is ignored while `O_ROM_REQ`=0, including in HOLD, DRAIN and RUN.
- `I_RELOAD` is ignored outside RUN.

## Timing

- Reset values, applied in the cycle after `I_RESET` is sampled high:
  - State is HOLD, and the hold counter is 0.
  - `O_CORE_N_RESET`=0, `O_ROM_REQ`=0, `O_ROM_ADDR`=0, `O_DATA`=8'h00, `O_DATA_OE`=0, `O_LOAD_STB`=0, `O_LOAD_CNT`=0, `O_DONE`=0.
- Latency from reset release to the first `O_ROM_REQ`: `HOLD_CYCLES` cycles.
- Latency from ack to strobe: exactly 1 cycle.
- With `I_ROM_ACK` tied high, throughput is 1 byte per cycle and RUN is reached `HOLD_CYCLES`+`PROG_BYTES`+1 cycles after reset release.
- Ack stalls: `O_ROM_REQ` and `O_ROM_ADDR` hold steady, `O_DATA` keeps its last value and `O_LOAD_STB` stays 0.
- `I_RESET` mid-load aborts the load. All outputs return to their reset values next cycle, and the core is re-held in reset.
- `I_RELOAD` together with `I_RESET`: reset wins; the result is identical.

## Test plan

- Ack held high, `PROG_BYTES`=8, `HOLD_CYCLES`=2, ROM[i]=8'hA0+i:
  - `O_CORE_N_RESET` is low for 2 cycles.
  - 8 strobes arrive on consecutive cycles carrying 8'hA0..8'hA7.
  - `O_DONE` rises at cycle 11, with `O_LOAD_CNT`=8 and `O_DATA_OE`=0.
- Ack low for 3 cycles at address 3:
  - `O_ROM_ADDR` stays at 3 throughout.
  - No strobe occurs.
  - Loading resumes and the byte order is intact.
- `I_RESET` pulsed after 5 strobes:
  - All outputs are at reset values next cycle.
  - A full reload follows, starting again from address 0.
- `I_RELOAD` pulsed in LOAD: ignored. `I_RELOAD` pulsed in RUN: `O_DONE`=0 and `O_CORE_N_RESET`=0 next cycle, then a full reload.
- `PROG_BYTES`=1:
  - Exactly one request and one strobe occur.
  - RUN is reached at `HOLD_CYCLES`+2.
- `ADDR_W`=3 with `PROG_BYTES`=8:
  - The final address is 7 with no wrap to 0.
  - `O_LOAD_CNT`=8.
  - No ninth request is issued.
